// File: rtl/neuron_forward_serial_pkg.sv
// Shared types and elaboration-time helpers for the serial neuron layer.
// FSM encoding, counter/accumulator sizing and clamp limits live here.
package neuron_forward_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Headroom for the bias plus NP products, each bounded by one WV-bit value.
    function automatic int acc_width_f(input int wv, input int np);
        return wv + clog2_f(np + 1) + 1;
    endfunction

    function automatic int cnt_width_f(input int np);
        return (np > 1) ? clog2_f(np) : 1;
    endfunction

    function automatic int sat_max_f(input int wv);
        return (1 << (wv - 1)) - 1;
    endfunction

    function automatic int sat_min_f(input int wv);
        return -(1 << (wv - 1));
    endfunction

endpackage

// File: rtl/neuron_forward_serial_mac_lane.sv
// One child-neuron MAC lane: bias load, scaled-product accumulate, clamp + activation.
// NEURON_LEAKY_RELU_EN selects leaky (v >>> 3) instead of plain ReLU for negative values.
module neuron_mac_lane
    import neuron_forward_serial_pkg::*;
#(
    parameter int WV = 8,
    parameter int AW = 12
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          load_i,
    input  logic          acc_en_i,
    input  logic          capture_i,
    input  logic [WV-1:0] bias_i,
    input  logic [WV-1:0] x_i,
    input  logic [WV-1:0] w_i,
    output logic [WV-1:0] y_o
);

    localparam logic signed [AW-1:0] SAT_MAX = AW'(sat_max_f(WV));
    localparam logic signed [AW-1:0] SAT_MIN = AW'(sat_min_f(WV));

    logic signed [2*WV-1:0] prod;
    logic signed [WV-1:0]   p;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [WV-1:0]   sat_v;
    logic signed [WV-1:0]   act_v;
    logic        [WV-1:0]   y_q;

    assign prod = $signed(x_i) * $signed(w_i);
    // Taking bits [WV-1 +: WV] is an arithmetic shift by the fraction width (floor).
    assign p    = prod[WV-1 +: WV];

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{(AW-WV){bias_i[WV-1]}}, bias_i};
        end else if (acc_en_i) begin
            acc_d = acc_q + {{(AW-WV){p[WV-1]}}, p};
        end
    end

    // Clamp first; activation only ever sees an in-range value.
    always_comb begin
        if (acc_d > SAT_MAX) begin
            sat_v = SAT_MAX[WV-1:0];
        end else if (acc_d < SAT_MIN) begin
            sat_v = SAT_MIN[WV-1:0];
        end else begin
            sat_v = acc_d[WV-1:0];
        end
    end

    always_comb begin
        act_v = sat_v;
        if (sat_v[WV-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
            act_v = sat_v >>> 3;
`else
            act_v = '0;
`endif
        end
    end

    // The capture sees acc_d so the last product is included in the registered output.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (capture_i) begin
                y_q <= act_v;
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/neuron_forward_serial.sv
// Serial-input neuron layer: NP inputs consumed one per cycle over NC parallel MAC lanes.
// Optional NEURON_LEAKY_RELU_EN (handled in the lanes) switches ReLU to leaky ReLU.
module neuron_forward_serial
    import neuron_forward_serial_pkg::*;
#(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WV = 8
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AS_WeightBias,
    output logic                     oReady_AS_WeightBias,
    input  logic [NP*NC*WV+NC*WV-1:0] iData_AS_WeightBias,
    input  logic                     iValid_AS_State0,
    output logic                     oReady_AS_State0,
    input  logic [NP*WV-1:0]         iData_AS_State0,
    output logic                     oValid_BM_State1,
    input  logic                     iReady_BM_State1,
    output logic [NC*WV-1:0]         oData_BM_State1
);

    localparam int AW = acc_width_f(WV, NP);
    localparam int KW = cnt_width_f(NP);
    localparam logic [KW-1:0] K_LAST = KW'(NP - 1);

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic              rdy_q;
    logic              vld_q;
    logic [NP*WV-1:0]  x_q;
    logic [NP*NC*WV-1:0] w_q;

    logic xfer;
    logic last_acc;
    logic acc_en;

    logic [WV-1:0] x_arr [NP];
    logic [WV-1:0] w_arr [NP][NC];
    logic [WV-1:0] y_arr [NC];

    // Join: both operands must be offered in the same cycle, otherwise nothing moves.
    assign xfer     = (state_q == ST_IDLE) && rdy_q
                      && iValid_AS_WeightBias && iValid_AS_State0;
    assign acc_en   = (state_q == ST_ACC);
    assign last_acc = acc_en && (k_q == K_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        state_q <= ST_ACC;
                        k_q     <= '0;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (last_acc) begin
                        state_q <= ST_OUT;
                        k_q     <= '0;
                        vld_q   <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Returning to IDLE rather than re-accepting leaves a deliberate bubble.
                    if (iReady_BM_State1) begin
                        state_q <= ST_IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    k_q     <= '0;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (xfer) begin
            x_q <= iData_AS_State0;
            w_q <= iData_AS_WeightBias[NP*NC*WV+NC*WV-1:NC*WV];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_x
            assign x_arr[gi] = x_q[gi*WV +: WV];
            for (gj = 0; gj < NC; gj++) begin : g_w
                assign w_arr[gi][gj] = w_q[(gi*NC+gj)*WV +: WV];
            end
        end

        for (gi = 0; gi < NC; gi++) begin : g_lane
            neuron_mac_lane #(
                .WV (WV),
                .AW (AW)
            ) u_lane (
                .iCLK      (iCLK),
                .iRST      (iRST),
                .load_i    (xfer),
                .acc_en_i  (acc_en),
                .capture_i (last_acc),
                .bias_i    (iData_AS_WeightBias[gi*WV +: WV]),
                .x_i       (x_arr[k_q]),
                .w_i       (w_arr[k_q][gi]),
                .y_o       (y_arr[gi])
            );
            assign oData_BM_State1[gi*WV +: WV] = y_arr[gi];
        end
    endgenerate

    assign oReady_AS_WeightBias = rdy_q;
    assign oReady_AS_State0     = rdy_q;
    assign oValid_BM_State1     = vld_q;

endmodule
